// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Imported by the packer and the loader FSM.
package loader_pkg;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERR
    } loader_state_t;

    localparam logic [7:0] CKSUM_SEED = 8'h00;
    localparam int DEF_ADDR_W = 14;
    localparam int DEF_LEN_W  = 16;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream handshake plus instruction-memory write bus.
// The loader is the slave; the byte source / memory side is the master.
interface instr_loader_if #(
    parameter int ADDR_W = 14
);
    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_data_o;
    logic              mem_wen_o;

    modport slave (
        input  byte_i,
        input  byte_valid_i,
        output byte_ready_o,
        output mem_addr_o,
        output mem_data_o,
        output mem_wen_o
    );

    modport master (
        output byte_i,
        output byte_valid_i,
        input  byte_ready_o,
        input  mem_addr_o,
        input  mem_data_o,
        input  mem_wen_o
    );
endinterface

// File: rtl/instr_loader_byte_packer.sv
// Little-endian byte-to-word packer with running XOR checksum.
// word_full flags the accept of the 4th byte of a word.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  din,
    output logic        word_full,
    output logic [31:0] word,
    output logic [7:0]  cksum
);

    logic [1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt   <= 2'd0;
            word  <= 32'd0;
            cksum <= CKSUM_SEED;
        end else if (accept) begin
            word[{cnt, 3'b000} +: 8] <= din;
            cnt   <= cnt + 2'd1;
            cksum <= cksum ^ din;
        end
    end

    assign word_full = accept && (cnt == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// Boot loader: parses a length header, writes packed words into instr_mem,
// verifies an XOR checksum and holds the core in reset until done.
module instr_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start_i,
    instr_loader_if.slave  bus,
    output logic           core_hold_o,
    output logic           done_o,
    output logic           err_o
);

    localparam int unsigned MAX_WORDS = 1 << ADDR_W;

    loader_state_t state, state_nx;

    logic [7:0]      len_lo;
    logic [LEN_W-1:0] hdr;
    logic [LEN_W-1:0] remaining;
    logic [ADDR_W:0]  widx;
    logic             unused_widx_msb;

    logic        accept;
    logic        pk_accept;
    logic        pk_clear;
    logic        word_full;
    logic [31:0] word;
    logic [7:0]  cksum;

    assign accept = bus.byte_valid_i && bus.byte_ready_o;
    assign hdr    = {bus.byte_i, len_lo};

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pk_clear),
        .accept    (pk_accept),
        .din       (bus.byte_i),
        .word_full (word_full),
        .word      (word),
        .cksum     (cksum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LEN_LO;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        bus.byte_ready_o = 1'b0;
        bus.mem_wen_o    = 1'b0;
        core_hold_o      = 1'b1;
        done_o           = 1'b0;
        err_o            = 1'b0;
        pk_accept        = 1'b0;
        pk_clear         = 1'b0;
        unique case (state)
            LEN_LO: begin
                bus.byte_ready_o = 1'b1;
                if (accept) state_nx = LEN_HI;
            end
            LEN_HI: begin
                bus.byte_ready_o = 1'b1;
                if (accept) begin
                    if (32'(hdr) > MAX_WORDS) state_nx = ERR;
                    else if (hdr == '0)       state_nx = CHECK;
                    else                      state_nx = DATA;
                end
            end
            DATA: begin
                bus.byte_ready_o = 1'b1;
                pk_accept        = accept;
                if (word_full) state_nx = WRITE;
            end
            WRITE: begin
                bus.mem_wen_o = 1'b1;
                state_nx = (remaining == LEN_W'(1)) ? CHECK : DATA;
            end
            CHECK: begin
                bus.byte_ready_o = 1'b1;
                if (accept) state_nx = (bus.byte_i == cksum) ? DONE : ERR;
            end
            DONE: begin
                done_o      = 1'b1;
                core_hold_o = 1'b0;
                if (start_i) begin
                    state_nx = LEN_LO;
                    pk_clear = 1'b1;
                end
            end
            ERR: begin
                err_o = 1'b1;
                if (start_i) begin
                    state_nx = LEN_LO;
                    pk_clear = 1'b1;
                end
            end
            default: state_nx = LEN_LO;
        endcase
    end

    // Header, word index and remaining count; widx has one spare bit so a
    // full-capacity image finishes without wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_lo    <= 8'd0;
            remaining <= '0;
            widx      <= '0;
        end else begin
            if (state == LEN_LO && accept) len_lo <= bus.byte_i;
            if (state == LEN_HI && accept) remaining <= hdr;
            if (state == WRITE) begin
                widx      <= widx + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (pk_clear) widx <= '0;
        end
    end

    assign bus.mem_addr_o = widx[ADDR_W-1:0];
    assign bus.mem_data_o = word;
    assign unused_widx_msb = widx[ADDR_W];

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader against a queue-based
// model of the stream format and expected memory writes.
module tb_instr_loader;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset;
    logic start_i;
    logic core_hold_o;
    logic done_o;
    logic err_o;

    int n_tests = 0;
    int n_fail  = 0;

    int          wa[$];
    logic [31:0] wd[$];
    logic [31:0] tb_mem[int];

    instr_loader_if #(.ADDR_W(14)) bus ();

    instr_loader #(.ADDR_W(14), .LEN_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .bus         (bus),
        .core_hold_o (core_hold_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory side: record every write strobe
    always @(negedge clk) begin
        if (bus.mem_wen_o === 1'b1) begin
            wa.push_back(int'(bus.mem_addr_o));
            wd.push_back(bus.mem_data_o);
            tb_mem[int'(bus.mem_addr_o)] = bus.mem_data_o;
            chk("ready_in_write", bus.byte_ready_o, 0);
        end
    end

    function automatic logic [7:0] xor_of(input bq_t d);
        logic [7:0] x = 8'h00;
        foreach (d[i]) x = x ^ d[i];
        return x;
    endfunction

    task automatic send(input logic [7:0] b, input int gmax);
        int n = 0;
        int gap = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.byte_valid_i = 1'b1;
        bus.byte_i       = b;
        while (bus.byte_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.byte_valid_i = 1'b0;
    endtask

    task automatic load(input string tag, input logic [15:0] len,
                        input bq_t d, input logic [7:0] ck, input int gmax);
        int n = 0;
        int oversize = (int'(len) > 16384);
        int ok = !oversize && (ck == xor_of(d));
        int nexp = oversize ? 0 : int'(len);
        wa.delete();
        wd.delete();
        send(len[7:0], gmax);
        send(len[15:8], gmax);
        if (!oversize) begin
            foreach (d[i]) send(d[i], gmax);
            send(ck, gmax);
        end
        while (!(done_o || err_o) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk({tag, "_finish_timeout"}, 0, 1);
        @(negedge clk);
        chk({tag, "_done"}, done_o, ok);
        chk({tag, "_err"}, err_o, !ok);
        chk({tag, "_hold"}, core_hold_o, !ok);
        chk({tag, "_nwrites"}, wa.size(), nexp);
        for (int i = 0; i < nexp && i < wa.size(); i++) begin
            chk({tag, "_addr"}, wa[i], i);
            chk({tag, "_data"}, wd[i],
                {d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]});
        end
    endtask

    task automatic rearm();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("rearm_hold", core_hold_o, 1);
        chk("rearm_done", done_o, 0);
        chk("rearm_err", err_o, 0);
        chk("rearm_ready", bus.byte_ready_o, 1);
    endtask

    function automatic bq_t rand_image(input int words);
        bq_t q;
        for (int i = 0; i < 4 * words; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin
        bq_t img;
        bq_t empty;
        bq_t rnd;
        bus.byte_valid_i = 1'b0;
        bus.byte_i       = 8'h00;
        start_i          = 1'b0;
        reset            = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_ready", bus.byte_ready_o, 1);
        chk("rst_hold", core_hold_o, 1);
        chk("rst_wen", bus.mem_wen_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_addr", bus.mem_addr_o, 0);
        chk("rst_data", bus.mem_data_o, 0);

        img = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h15, 8'h00};
        load("two_word", 16'd2, img, xor_of(img), 0);
        chk("two_word_w0", tb_mem[0], 32'h0000_0513);
        chk("two_word_w1", tb_mem[1], 32'h0015_0593);
        rearm();

        load("bad_ck", 16'd2, img, 8'h81, 0);
        rearm();

        load("len0", 16'd0, empty, 8'h00, 0);
        rearm();

        load("oversize", 16'h4001, empty, 8'h00, 0);
        chk("oversize_ready", bus.byte_ready_o, 0);
        rearm();

        rnd = rand_image(16);
        load("gaps16", 16'd16, rnd, xor_of(rnd), 5);
        rearm();
        load("nogap16", 16'd16, rnd, xor_of(rnd), 0);
        rearm();

        // Abandon a load after six data bytes
        img = rand_image(2);
        send(8'd2, 0);
        send(8'd0, 0);
        for (int i = 0; i < 6; i++) send(img[i], 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_wen", bus.mem_wen_o, 0);
        chk("midrst_hold", core_hold_o, 1);
        chk("midrst_ready", bus.byte_ready_o, 1);
        chk("midrst_addr", bus.mem_addr_o, 0);
        img = rand_image(1);
        load("after_rst", 16'd1, img, xor_of(img), 2);

        chk("pre_rearm_hold", core_hold_o, 0);
        rearm();
        img = rand_image(1);
        load("reload", 16'd1, img, xor_of(img), 1);
        chk("reload_w0", tb_mem[0], {img[3], img[2], img[1], img[0]});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule
